// File: rtl/pwm_duty_ramp.sv
// Breathing triangle duty source for timer_pwm_core; duty only moves on period_done.
// Optional hold states at each extreme are enabled by defining PWM_RAMP_HOLD_EN.
module pwm_duty_ramp #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned HOLD_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             period_done,
  input  logic [WIDTH-1:0] duty_max,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] duty,
  output logic             duty_upd,
  output logic [2:0]       state,
  output logic             cycle_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD_HIGH = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_HOLD_LOW  = 3'd4
  } state_t;

  state_t st;

`ifdef PWM_RAMP_HOLD_EN
  localparam int unsigned HOLD_LAST = (HOLD_PERIODS == 0) ? 0 : HOLD_PERIODS - 1;
  localparam int unsigned HCW       = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  logic [HCW-1:0] hold_cnt;
`endif

  // Candidate next duty values; up_sum is one bit wider so it cannot wrap.
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_diff;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] clamp_val;

  assign up_sum    = {1'b0, duty} + {1'b0, step};
  assign up_val    = (up_sum > {1'b0, duty_max}) ? duty_max : up_sum[WIDTH-1:0];
  assign dn_diff   = (duty > step) ? (duty - step) : '0;
  assign dn_val    = (dn_diff > duty_max) ? duty_max : dn_diff;
  assign clamp_val = (duty > duty_max) ? duty_max : duty;

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      duty       <= '0;
      duty_upd   <= 1'b0;
      cycle_done <= 1'b0;
`ifdef PWM_RAMP_HOLD_EN
      hold_cnt   <= '0;
`endif
    end else begin
      duty_upd   <= 1'b0;
      cycle_done <= 1'b0;
      if (!enable) begin
        st       <= S_IDLE;
        duty     <= '0;
        duty_upd <= (duty != '0);
`ifdef PWM_RAMP_HOLD_EN
        hold_cnt <= '0;
`endif
      end else if (st == S_IDLE) begin
        st <= S_RAMP_UP;
      end else if (period_done) begin
        case (st)
          S_RAMP_UP: begin
            duty     <= up_val;
            duty_upd <= (up_val != duty);
            if (up_val == duty_max) begin
`ifdef PWM_RAMP_HOLD_EN
              if (HOLD_PERIODS == 0) begin
                st <= S_RAMP_DOWN;
              end else begin
                st       <= S_HOLD_HIGH;
                hold_cnt <= '0;
              end
`else
              st <= S_RAMP_DOWN;
`endif
            end
          end
          S_RAMP_DOWN: begin
            duty     <= dn_val;
            duty_upd <= (dn_val != duty);
            if (dn_val == '0) begin
`ifdef PWM_RAMP_HOLD_EN
              if (HOLD_PERIODS == 0) begin
                st         <= S_RAMP_UP;
                cycle_done <= 1'b1;
              end else begin
                st       <= S_HOLD_LOW;
                hold_cnt <= '0;
              end
`else
              st         <= S_RAMP_UP;
              cycle_done <= 1'b1;
`endif
            end
          end
`ifdef PWM_RAMP_HOLD_EN
          S_HOLD_HIGH: begin
            duty     <= clamp_val;
            duty_upd <= (clamp_val != duty);
            if (hold_cnt == HCW'(HOLD_LAST)) begin
              st       <= S_RAMP_DOWN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end
          S_HOLD_LOW: begin
            duty     <= clamp_val;
            duty_upd <= (clamp_val != duty);
            if (hold_cnt == HCW'(HOLD_LAST)) begin
              st         <= S_RAMP_UP;
              cycle_done <= 1'b1;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end
`endif
          default: begin
            st   <= S_IDLE;
            duty <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp; expectations follow PWM_RAMP_HOLD_EN when defined.
module tb_pwm_duty_ramp;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         period_done;
  logic [W-1:0] duty_max;
  logic [W-1:0] step;
  logic [W-1:0] duty;
  logic         duty_upd;
  logic [2:0]   state;
  logic         cycle_done;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.WIDTH(W), .HOLD_PERIODS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period_done(period_done),
    .duty_max   (duty_max),
    .step       (step),
    .duty       (duty),
    .duty_upd   (duty_upd),
    .state      (state),
    .cycle_done (cycle_done)
  );

`ifdef PWM_RAMP_HOLD_EN
  localparam logic [2:0] TOP = 3'd2;
  localparam bit         HOLD = 1'b1;
`else
  localparam logic [2:0] TOP = 3'd3;
  localparam bit         HOLD = 1'b0;
`endif

  typedef struct {
    logic         en;
    logic         pd;
    logic [W-1:0] dmax;
    logic [W-1:0] stp;
    logic [W-1:0] e_duty;
    logic         e_upd;
    logic [2:0]   e_st;
    logic         e_cd;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] ed, input logic eu,
                          input logic [2:0] es, input logic ec);
    chk({tag, " duty"}, duty, ed);
    chk({tag, " duty_upd"}, W'(duty_upd), W'(eu));
    chk({tag, " state"}, W'(state), W'(es));
    chk({tag, " cycle_done"}, W'(cycle_done), W'(ec));
  endtask

  task automatic v(input logic en, input logic pd, input logic [W-1:0] dm, input logic [W-1:0] sp,
                   input logic [W-1:0] ed, input logic eu, input logic [2:0] es, input logic ec);
    vec_t t;
    t.en = en; t.pd = pd; t.dmax = dm; t.stp = sp;
    t.e_duty = ed; t.e_upd = eu; t.e_st = es; t.e_cd = ec;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] e6_d  [6];
  logic [2:0]   e6_s  [6];
  logic         e6_u  [6];
  logic         e6_c  [6];

  initial begin
    // Ramp 0..10 by 3, top, then down to 0 with consecutive period_done pulses
    v(1,0,10,3, 0,0,1,0);
    v(1,1,10,3, 3,1,1,0);
    v(1,0,10,3, 3,0,1,0);
    v(1,1,10,3, 6,1,1,0);
    v(1,1,10,3, 9,1,1,0);
    v(1,1,10,3, 10,1,TOP,0);
    if (HOLD) begin
      v(1,1,10,3, 10,0,2,0);
      v(1,1,10,3, 10,0,3,0);
    end
    v(1,1,10,3, 7,1,3,0);
    v(1,0,10,3, 7,0,3,0);
    v(1,1,10,3, 4,1,3,0);
    v(1,1,10,3, 1,1,3,0);
    if (HOLD) begin
      v(1,1,10,3, 0,1,4,0);
      v(1,1,10,3, 0,0,4,0);
      v(1,1,10,3, 0,0,1,1);
    end else begin
      v(1,1,10,3, 0,1,1,1);
    end
    v(1,0,10,3, 0,0,1,0);
    // Disable at duty 6, period_done ignored while off, re-enable keeps duty 0
    v(1,1,10,3, 3,1,1,0);
    v(1,1,10,3, 6,1,1,0);
    v(0,0,10,3, 0,1,0,0);
    v(0,1,10,3, 0,0,0,0);
    v(1,1,10,3, 0,0,1,0);
    v(1,1,10,3, 3,1,1,0);
    // Ceiling lowered under a running ramp
    v(1,1,10,3, 6,1,1,0);
    v(1,1,10,3, 9,1,1,0);
    v(1,1,5,3,  5,1,TOP,0);
    v(0,0,5,3,  0,1,0,0);
    v(0,0,5,3,  0,0,0,0);
    // Near-full-scale sums must saturate, large down-steps must floor at zero
    v(1,0,16'hFFF0,16'h0020, 16'h0000,0,1,0);
    v(1,1,16'hFFF0,16'h0020, 16'h0020,1,1,0);
    v(1,1,16'hFFF0,16'hFFE0, 16'hFFF0,1,TOP,0);
    if (HOLD) begin
      v(1,1,16'hFFF0,16'hFFE0, 16'hFFF0,0,2,0);
      v(1,1,16'hFFF0,16'hFFE0, 16'hFFF0,0,3,0);
    end
    v(1,1,16'hFFF0,16'hFFE0, 16'h0010,1,3,0);
    v(1,1,16'hFFF0,16'hFFE0, 16'h0000,1,HOLD ? 3'd4 : 3'd1,!HOLD);
    // step = 0 freezes duty
    v(0,0,9,2, 0,0,0,0);
    v(1,0,9,2, 0,0,1,0);
    v(1,1,9,2, 2,1,1,0);
    v(1,1,9,0, 2,0,1,0);
    v(1,1,9,0, 2,0,1,0);
    // duty_max = 0 reaches the top on the first update
    v(0,0,0,5, 0,1,0,0);
    v(1,0,0,5, 0,0,1,0);
    v(1,1,0,5, 0,0,TOP,0);
    v(0,0,0,5, 0,0,0,0);

    if (HOLD) begin
      e6_d = '{16'd4, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0};
      e6_s = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1};
      e6_u = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      e6_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    end else begin
      e6_d = '{16'd4, 16'd0, 16'd4, 16'd0, 16'd4, 16'd0};
      e6_s = '{3'd3, 3'd1, 3'd3, 3'd1, 3'd3, 3'd1};
      e6_u = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      e6_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    end

    rst = 1'b1; enable = 1'b0; period_done = 1'b0; duty_max = '0; step = '0;
    tick();
    chk_outs("reset", 0, 0, 0, 0);

    // Asynchronous reset in the middle of a ramp
    rst = 1'b0; enable = 1'b1; duty_max = 16'd10; step = 16'd3;
    tick();
    period_done = 1'b1;
    tick();
    tick();
    period_done = 1'b0;
    chk_outs("pre_rst", 6, 1, 1, 0);
    #2 rst = 1'b1;
    #1 chk_outs("rst_async", 0, 0, 0, 0);
    period_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("rst_hold%0d", i), 0, 0, 0, 0);
    end
    rst = 1'b0; enable = 1'b0; period_done = 1'b0;
    tick();
    chk_outs("rst_rel", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      enable = vecs[i].en; period_done = vecs[i].pd;
      duty_max = vecs[i].dmax; step = vecs[i].stp;
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_duty, vecs[i].e_upd, vecs[i].e_st, vecs[i].e_cd);
    end

    // Full-scale step: bounce between 0 and duty_max every update
    enable = 1'b0; period_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; enable = 1'b1; duty_max = 16'd4; step = 16'd4;
    tick();
    chk_outs("bounce_start", 0, 0, 1, 0);
    period_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_outs($sformatf("bounce%0d", i), e6_d[i], e6_u[i], e6_s[i], e6_c[i]);
    end
    period_done = 1'b0;
    tick();
    chk_outs("bounce_end", e6_d[5], 0, e6_s[5], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
